blink_gen: RTL and testbench
============================

# blink_gen

Free-running LED blink generator: divides the system clock into a programmable on/off waveform on a single registered output `q`. Optionally groups blinks into bursts separated by a long dark gap. It sits at the board top level, driving a status LED directly. It has no handshake and no software control, and runs continuously out of reset.

## Interface
- `ON_CYCLES`, default 5: clock cycles `q` is high per pulse; must be at least 1.
- `OFF_CYCLES`, default 5: clock cycles `q` is low between pulses; must be at least 1.
- `PULSES`, default 3: pulses per burst; must be at least 1. Used only with `BLINK_BURST_EN`.
- `GAP_CYCLES`, default 20: low cycles after the last pulse of a burst; must be at least 1. Used only with `BLINK_BURST_EN`.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low. Low forces reset state immediately; deassertion is sampled on `clk`.
- `q` output, 1 bit: blink output, registered. High means LED on.

## Operation
- Internal counters:
  - Phase down-counter `cnt`, width `$clog2` of the largest of `ON_CYCLES`, `OFF_CYCLES` and `GAP_CYCLES`, with a minimum of 1.
  - Pulse counter `pcnt`, width `$clog2(PULSES+1)`.
- States:
  - IDLE: reset only.
  - ON.
  - OFF.
  - GAP: exists only with `BLINK_BURST_EN`.
- Reset (`rst` = 0): state IDLE, `cnt` = 0, `pcnt` = 0, `q` = 0. This applies at any time, including mid-phase; there is no partial phase completion.
- IDLE → ON on the first clock edge with `rst` = 1. On entry, load `cnt` = ON_CYCLES-1 and set `q` = 1.
- ON:
  - When `cnt` == 0, go to OFF, load OFF_CYCLES-1, set `q` = 0, `pcnt` += 1.
  - Otherwise `cnt` -= 1.
- OFF:
  - When `cnt` == 0, go to ON, load ON_CYCLES-1, set `q` = 1.
  - Otherwise `cnt` -= 1.
- With `BLINK_BURST_EN`, ON at `cnt` == 0 with `pcnt` == PULSES-1:
  - Go to GAP instead of OFF.
  - Load GAP_CYCLES-1, set `q` = 0, clear `pcnt`.
- GAP:
  - When `cnt` == 0, go to ON, load ON_CYCLES-1, set `q` = 1.
  - Otherwise `cnt` -= 1.
- `q` is 1 exactly when the state is ON. It is a flop output with no combinational path from `rst` other than the async clear.
- Any parameter equal to 1 produces a single-cycle phase, with no stalls or skipped phases.
- Counters never wrap. They are reloaded at each phase boundary.

## Timing
- First rising edge of `q`: edge 1 after `rst` deasserts, i.e. the edge at which IDLE exits.
- `q` high for exactly ON_CYCLES consecutive edges, then low for exactly OFF_CYCLES edges.
- Continuous mode:
  - Period = ON_CYCLES + OFF_CYCLES.
  - Defaults: period 10 cycles, 50 % duty.
- Burst mode:
  - Burst period = PULSES·ON_CYCLES + (PULSES-1)·OFF_CYCLES + GAP_CYCLES.
  - Defaults: 45 cycles. The pattern is H5 L5 H5 L5 H5 L20.
- Reset assertion drives `q` to 0 asynchronously, within the flop clear delay, with no clock required.

## Configuration
- `BLINK_BURST_EN` defined: GAP state and `pcnt` are compiled in; burst pattern as above.
- Not defined: GAP state and `pcnt` are absent. The output is a plain ON/OFF square wave, and `PULSES` and `GAP_CYCLES` are ignored.

## Test plan
- Reset hold: with `rst` = 0 for 10 cycles, `q` = 0 throughout. After release, `q` = 1 on the first edge.
- Continuous defaults, 500 cycles after release (no macro): `q` toggles every 5 cycles, giving exactly 50 rising edges.
- Burst defaults (`BLINK_BURST_EN`): measured high/low run lengths repeat 5,5,5,5,5,20. The first burst starts 1 cycle after release.
- Asymmetric `ON_CYCLES`=1, `OFF_CYCLES`=3 (no macro): `q` = 1000 repeating, with period 4.
- Mid-phase reset: assert `rst` = 0 at cycle 3 of an ON phase. `q` falls to 0 without waiting for a clock edge. After release the pattern restarts with a full 5-cycle ON phase, and in burst mode the pulse count restarts at the first pulse.
- Degenerate burst, `PULSES`=1, `GAP_CYCLES`=1, `ON_CYCLES`=1: `q` alternates 1,0 every cycle, and the OFF state is never entered.

Source files
------------

// File: rtl/blink_gen.sv
// blink_gen: free-running LED blink generator producing a programmable on/off waveform on q.
// Define BLINK_BURST_EN to group PULSES pulses into bursts separated by a GAP_CYCLES dark gap.
module blink_gen #(
    parameter int unsigned ON_CYCLES  = 5,
    parameter int unsigned OFF_CYCLES = 5,
    parameter int unsigned PULSES     = 3,
    parameter int unsigned GAP_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    output logic q
);

    localparam int unsigned MAX_OO  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_OO > GAP_CYCLES) ? MAX_OO : GAP_CYCLES;
    localparam int unsigned CW      = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    // Reject configurations that would produce zero-length phases.
    if (ON_CYCLES < 1) begin : g_bad_on
        $error("blink_gen: ON_CYCLES must be at least 1");
    end
    if (OFF_CYCLES < 1) begin : g_bad_off
        $error("blink_gen: OFF_CYCLES must be at least 1");
    end
    if (PULSES < 1) begin : g_bad_pulses
        $error("blink_gen: PULSES must be at least 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("blink_gen: GAP_CYCLES must be at least 1");
    end

`ifdef BLINK_BURST_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int unsigned   PW         = $clog2(PULSES + 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] LAST_PULSE = PW'(PULSES - 1);

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_n;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;
`endif

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          q_n;

    // State, phase counter and output flop; reset clears everything with no clock needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= 1'b0;
`ifdef BLINK_BURST_EN
            pcnt  <= '0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
`ifdef BLINK_BURST_EN
            pcnt  <= pcnt_n;
`endif
        end
    end

    // Next-state and counter reload at phase boundaries; counters only count down to zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
`ifdef BLINK_BURST_EN
        pcnt_n  = pcnt;
`endif
        case (state)
            IDLE: begin
                state_n = ON;
                cnt_n   = ON_LOAD;
            end
            ON: begin
                if (cnt == '0) begin
`ifdef BLINK_BURST_EN
                    if (pcnt == LAST_PULSE) begin
                        state_n = GAP;
                        cnt_n   = GAP_LOAD;
                        pcnt_n  = '0;
                    end else begin
                        state_n = OFF;
                        cnt_n   = OFF_LOAD;
                        pcnt_n  = pcnt + PW'(1);
                    end
`else
                    state_n = OFF;
                    cnt_n   = OFF_LOAD;
`endif
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            OFF: begin
                if (cnt == '0) begin
                    state_n = ON;
                    cnt_n   = ON_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
`ifdef BLINK_BURST_EN
            GAP: begin
                if (cnt == '0) begin
                    state_n = ON;
                    cnt_n   = ON_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
`endif
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        q_n = (state_n == ON);
    end

endmodule

// File: tb/tb_blink_gen.sv
// tb_blink_gen: randomized self-checking bench for blink_gen against a pattern-level reference model.
// Two instances: defaults, and ON=1/OFF=3/PULSES=1/GAP=1 (asymmetric or degenerate-burst case).
module tb_blink_gen;

`ifdef BLINK_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic q0;
    logic q1;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;

    always #5 clk = ~clk;

    blink_gen u_dflt (
        .clk (clk),
        .rst (rst),
        .q   (q0)
    );

    blink_gen #(
        .ON_CYCLES  (1),
        .OFF_CYCLES (3),
        .PULSES     (1),
        .GAP_CYCLES (1)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .q   (q1)
    );

    // Expected q after the k-th rising edge since reset release, from the waveform definition.
    function automatic logic model_q(input int kk, input int on, input int off,
                                     input int pulses, input int gap);
        int per;
        int p;
        if (kk <= 0) return 1'b0;
        if (BURST) begin
            per = pulses * on + (pulses - 1) * off + gap;
            p   = (kk - 1) % per;
            for (int i = 0; i < pulses; i++) begin
                if (p < on) return 1'b1;
                p -= on;
                if (i == pulses - 1) return 1'b0;
                if (p < off) return 1'b0;
                p -= off;
            end
            return 1'b0;
        end else begin
            per = on + off;
            p   = (kk - 1) % per;
            return (p < on);
        end
    endfunction

    function automatic logic exp0(input int kk);
        return model_q(kk, 5, 5, 3, 20);
    endfunction

    function automatic logic exp1(input int kk);
        return model_q(kk, 1, 3, 1, 1);
    endfunction

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        k   = 0;
    endtask

    // Advance n edges, checking both instances mid-cycle against the model.
    task automatic run_check(input int n, input string name, inout int rises);
        logic prev;
        prev = q0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            n_tests++;
            if (q0 !== exp0(k)) begin
                n_fail++;
                $display("FAIL %s dflt k=%0d q=%b expected=%b", name, k, q0, exp0(k));
            end
            n_tests++;
            if (q1 !== exp1(k)) begin
                n_fail++;
                $display("FAIL %s small k=%0d q=%b expected=%b", name, k, q1, exp1(k));
            end
            if (q0 && !prev) rises++;
            prev = q0;
        end
    endtask

    task automatic test_reset();
        int hold;
        hold = 10 + int'($urandom_range(0, 5));
        rst  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_tests++;
            if (q0 !== 1'b0 || q1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cycle=%0d q=%b/%b expected=0/0", i, q0, q1);
            end
        end
    endtask

    task automatic test_continuous();
        int rises;
        int exp_rises;
        logic prev;
        rises = 0;
        release_rst();
        run_check(500, "continuous", rises);
        exp_rises = 0;
        prev      = 1'b0;
        for (int i = 1; i <= 500; i++) begin
            if (exp0(i) && !prev) exp_rises++;
            prev = exp0(i);
        end
        n_tests++;
        if (rises !== exp_rises) begin
            n_fail++;
            $display("FAIL rise_count got=%0d expected=%0d", rises, exp_rises);
        end
    endtask

    // Assert reset asynchronously on the third cycle of an ON phase, then verify a clean restart.
    task automatic test_mid_phase_reset();
        int   dummy;
        int   min_k;
        logic found;
        dummy = 0;
        found = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        release_rst();
        min_k = int'($urandom_range(3, 60));
        for (int i = 0; i < 300 && !found; i++) begin
            run_check(1, "mid_pre", dummy);
            if (k >= min_k && exp0(k) && exp0(k - 1) && exp0(k - 2) && !exp0(k - 3))
                found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_phase_timeout k=%0d expected an ON phase cycle 3", k);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (q0 !== 1'b0 || q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_clear q=%b/%b expected=0/0", q0, q1);
        end
        repeat (int'($urandom_range(1, 4))) @(negedge clk);
        release_rst();
        run_check(100, "mid_restart", dummy);
    endtask

    task automatic test_random_resets();
        int dummy;
        dummy = 0;
        for (int r = 0; r < 6; r++) begin
            run_check(int'($urandom_range(1, 120)), "rand_run", dummy);
            #(int'($urandom_range(1, 3)));
            rst = 1'b0;
            #1;
            n_tests++;
            if (q0 !== 1'b0 || q1 !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_async_clear iter=%0d q=%b/%b expected=0/0", r, q0, q1);
            end
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
            release_rst();
        end
        run_check(60, "rand_tail", dummy);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_mid_phase_reset();
        test_random_resets();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
